qadd_pipe: RTL

QADD_PIPE -- requirements
Module: qadd_pipe

---
 rtl/qadd_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/qadd_pipe.sv
// qadd_pipe: LANES-wide two's-complement add/sub with per-lane overflow, saturating (SAT=1) or wrapping (SAT=0).
// Latency: 2 cycles from input transfer to out_valid; sustains one beat per cycle while out_ready is high.
// Backpressure: valid/ready; in_ready drops combinationally when both stages hold beats and out_ready is low.
// Optional feature: define QADD_PIPE_OVF_STICKY_EN to add the ovf_sticky output and its register.
module qadd_pipe #(
  parameter int N     = 16,
  parameter int Q     = 12,
  parameter int LANES = 1,
  parameter int SAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] a,
  input  logic [LANES*N-1:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] c,
  output logic [LANES-1:0]   ovf
`ifdef QADD_PIPE_OVF_STICKY_EN
  ,
  output logic               ovf_sticky
`endif
);

  // Q only describes the number format; it is checked here and never touches the datapath.
  if (N < 4 || Q < 0 || Q >= N || LANES < 1) begin : g_bad_params
    $error("qadd_pipe: illegal parameter combination");
  end

  localparam int W = N + 1;

  logic                 s1_vld_q;
  logic [LANES*W-1:0]   s1_sum_q;
  logic [LANES*W-1:0]   s1_sum_d;
  logic                 s2_vld_q;
  logic [LANES*N-1:0]   s2_c_q;
  logic [LANES*N-1:0]   s2_c_d;
  logic [LANES-1:0]     s2_ovf_q;
  logic [LANES-1:0]     s2_ovf_d;
  logic                 s1_adv;
  logic                 s2_adv;

  // S2 moves when it is empty or its beat leaves; S1 moves when it is empty or S2 moves.
  assign s2_adv    = !s2_vld_q || out_ready;
  assign s1_adv    = !s1_vld_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_vld_q;
  assign c         = s2_c_q;
  assign ovf       = s2_ovf_q;

  // Exact (N+1)-bit sum or difference of the sign-extended operands, per lane.
  always_comb begin
    s1_sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sub) begin
        s1_sum_d[i*W +: W] = {a[i*N+N-1], a[i*N +: N]} - {b[i*N+N-1], b[i*N +: N]};
      end else begin
        s1_sum_d[i*W +: W] = {a[i*N+N-1], a[i*N +: N]} + {b[i*N+N-1], b[i*N +: N]};
      end
    end
  end

  // Overflow is a disagreement between the two top bits; the extra top bit gives the true sign for clamping.
  always_comb begin
    s2_c_d   = '0;
    s2_ovf_d = '0;
    for (int i = 0; i < LANES; i++) begin
      s2_ovf_d[i] = s1_sum_q[i*W+N] ^ s1_sum_q[i*W+N-1];
      if (s2_ovf_d[i] && (SAT != 0)) begin
        s2_c_d[i*N +: N] = s1_sum_q[i*W+N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else begin
        s2_c_d[i*N +: N] = s1_sum_q[i*W +: N];
      end
    end
  end

  // Stage 1: capture the extended sum of an accepted beat; reset discards any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_sum_q <= '0;
    end else if (s1_adv) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_sum_q <= s1_sum_d;
      end
    end
  end

  // Stage 2: register the clamped/wrapped result; holds while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q <= 1'b0;
      s2_c_q   <= '0;
      s2_ovf_q <= '0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_c_q   <= s2_c_d;
        s2_ovf_q <= s2_ovf_d;
      end
    end
  end

`ifdef QADD_PIPE_OVF_STICKY_EN
  logic sticky_q;
  logic sticky_d;

  assign sticky_d   = sticky_q | (s2_vld_q & out_ready & (|s2_ovf_q));
  assign ovf_sticky = sticky_q;

  // Sticky flag: remembers any overflowing beat that left the block, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`endif

endmodule
